// File: rtl/div_lz_iter_pkg.sv
// Shared types and constants for the leading-zero-skipping iterative divider.
// Holds the FSM encoding, the divide-by-zero quotient and a negate-if helper.
package div_lz_iter_pkg;

  localparam int WIDTH = 32;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Operand context captured with start and needed until the final sign fixup.
  typedef struct packed {
    logic             sgn_n;
    logic             sgn_d;
    logic [WIDTH-1:0] mag_d;
    logic [WIDTH-1:0] dvd_orig;
  } op_t;

  function automatic logic [WIDTH-1:0] neg_if(input logic c, input logic [WIDTH-1:0] v);
    return c ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_lz_iter_if.sv
// Request/result bundle between the pipeline (master) and the divider (slave).
// busy is the stall back to the pipeline; there is no other backpressure.
interface div_lz_iter_if;
  import div_lz_iter_pkg::*;

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/div_lz_iter_step.sv
// One restoring-division iteration, purely combinational (zero latency).
// No handshake: the caller registers r_next/q_next when it wants to advance.
module div_step
  import div_lz_iter_pkg::*;
(
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;
  logic           ge;

  assign t    = {r, q[WIDTH-1]};
  assign ge   = (t >= {1'b0, d});
  assign diff = t - {1'b0, d};

  // r < d is invariant, so t - d always fits back into WIDTH bits.
  assign r_next = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ge};

endmodule

// File: rtl/div_lz_iter.sv
// Iterative 32-bit DIV/DIVU that skips leading zeros reported by an external counter.
// Latency 32-lz+3 cycles (2 for zero divisor/dividend); busy stalls upstream, no other backpressure.
module div_lz_iter
  import div_lz_iter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  div_lz_iter_if.slave     dif,
  output logic [WIDTH-1:0] mag_q,
  input  logic [5:0]       lz_in
);

  logic [2:0]       state;
  op_t              op;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic [5:0]       lz_c;
  logic             accept;
  logic             sgn_n_in;
  logic             sgn_d_in;

  assign accept   = dif.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign lz_c     = (lz_in > 6'd32) ? 6'd32 : lz_in;
  assign sgn_n_in = dif.is_signed & dif.dividend[WIDTH-1];
  assign sgn_d_in = dif.is_signed & dif.divisor[WIDTH-1];

  assign dif.busy      = (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIX);
  assign dif.done      = (state == ST_DONE);
  assign dif.quotient  = quotient;
  assign dif.remainder = remainder;

  div_step u_step (
    .r      (r),
    .q      (q),
    .d      (op.mag_d),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op        <= '0;
      mag_q     <= '0;
      q         <= '0;
      r         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            op.sgn_n    <= sgn_n_in;
            op.sgn_d    <= sgn_d_in;
            op.mag_d    <= neg_if(sgn_d_in, dif.divisor);
            op.dvd_orig <= dif.dividend;
            mag_q       <= neg_if(sgn_n_in, dif.dividend);
            state       <= ST_PREP;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_PREP: begin
          if (op.mag_d == '0) begin
            // Divide by zero reports the raw dividend, without sign fixup.
            quotient  <= DIV0_QUOTIENT;
            remainder <= op.dvd_orig;
            state     <= ST_DONE;
          end else if (lz_c == 6'd32) begin
            quotient  <= '0;
            remainder <= '0;
            state     <= ST_DONE;
          end else begin
            q     <= mag_q << lz_c;
            r     <= '0;
            cnt   <= 6'd32 - lz_c;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          quotient  <= neg_if(op.sgn_n ^ op.sgn_d, q);
          remainder <= neg_if(op.sgn_n, r);
          state     <= ST_DONE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_lz_iter.sv
// Self-checking bench: directed literal cases plus random traffic against a cycle-timeline model.
// The model derives results from plain integer division and latency from the leading-zero count.
module tb_div_lz_iter;

  logic        clk;
  logic        rst;
  logic [31:0] mag_q;
  logic [5:0]  lz_in;
  bit          lz_force;

  int n_checks = 0;
  int n_err    = 0;

  div_lz_iter_if dif();

  div_lz_iter dut (
    .clk   (clk),
    .rst   (rst),
    .dif   (dif),
    .mag_q (mag_q),
    .lz_in (lz_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clz(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return 31 - i;
    end
    return 32;
  endfunction

  // Leading-zero counter; optionally reports an out-of-range count for a zero input.
  always_comb lz_in = (lz_force && mag_q == 32'd0) ? 6'd40 : 6'(clz(mag_q));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: results from plain integer arithmetic, latency from the skip rule.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eq, output logic [31:0] er,
                                  output logic [31:0] mag, output int lat);
    longint sa, sb, qq, rr;
    mag = (s && a[31]) ? -a : a;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; lat = 2;
    end else if (mag == 32'd0) begin
      eq = 32'd0; er = 32'd0; lat = 2;
    end else begin
      lat = 32 - clz(mag) + 3;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      qq = sa / sb;
      rr = sa % sb;
      eq = qq[31:0];
      er = rr[31:0];
    end
  endfunction

  // Timeline model: m_t is the cycle index within the current operation.
  bit          m_init = 0;
  bit          m_active = 0;
  int          m_t = 0;
  int          m_lat = 0;
  int          m_ndone = 0;
  logic [31:0] m_exp_q, m_exp_r;
  logic [31:0] m_res_q = 0, m_res_r = 0, m_mag = 0;

  always @(posedge clk) begin
    bit was_done;
    m_init = 1;
    if (rst) begin
      m_active = 0; m_t = 0;
      m_res_q = 0; m_res_r = 0; m_mag = 0;
    end else begin
      was_done = m_active && (m_t == m_lat);
      if (dif.start && (!m_active || was_done)) begin
        ref_div(dif.is_signed, dif.dividend, dif.divisor, m_exp_q, m_exp_r, m_mag, m_lat);
        m_active = 1;
        m_t = 1;
      end else if (m_active) begin
        if (was_done) m_active = 0;
        else m_t++;
      end
      if (m_active && m_t == m_lat) begin
        m_res_q = m_exp_q;
        m_res_r = m_exp_r;
        m_ndone++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("busy", dif.busy, (m_active && m_t < m_lat));
      chk("done", dif.done, (m_active && m_t == m_lat));
      chk("quotient", dif.quotient, m_res_q);
      chk("remainder", dif.remainder, m_res_r);
      chk("mag_q", mag_q, m_mag);
    end
  end

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    dif.start = 1'b1; dif.is_signed = s; dif.dividend = a; dif.divisor = b;
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int k0, input int exp_lat,
                           input logic [31:0] eq, input logic [31:0] er);
    int k = k0;
    while (!dif.done && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_timeout"}, dif.done, 1'b1);
    chk({nm, "_latency"}, k, exp_lat);
    chk({nm, "_q"}, dif.quotient, eq);
    chk({nm, "_r"}, dif.remainder, er);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return $urandom_range(0, 255);
      2: return 32'd0;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    rst = 1'b1; lz_force = 0;
    dif.start = 0; dif.is_signed = 0; dif.dividend = 0; dif.divisor = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_busy", dif.busy, 0);
    chk("reset_done", dif.done, 0);
    chk("reset_q", dif.quotient, 0);
    chk("reset_r", dif.remainder, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 32'd100, 32'd7);
    wait_done("divu_100_7", 1, 10, 32'd14, 32'd2);
    @(negedge clk);
    issue(1, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", 1, 6, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    @(negedge clk);
    issue(1, 32'h8000_0005, 32'd0);
    wait_done("div0", 1, 2, 32'hFFFF_FFFF, 32'h8000_0005);
    @(negedge clk);
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("ovf_signed", 1, 35, 32'h8000_0000, 32'd0);
    @(negedge clk);
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("ovf_unsigned", 1, 35, 32'd0, 32'h8000_0000);
    @(negedge clk);
    issue(0, 32'd0, 32'd9);
    wait_done("zero_dvd", 1, 2, 32'd0, 32'd0);
    @(negedge clk);
    lz_force = 1;
    issue(1, 32'd0, 32'd9);
    wait_done("lz_clamp", 1, 2, 32'd0, 32'd0);
    lz_force = 0;
    @(negedge clk);

    // Start pulse mid-RUN must be ignored.
    issue(0, 32'd100, 32'd7);
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 32'd5; dif.divisor = 32'd1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_done("ignore_start", 3, 10, 32'd14, 32'd2);

    // Back-to-back: start in the DONE cycle enters PREP next cycle.
    issue(1, 32'hFFFF_FFF9, 32'd2);
    chk("b2b_prep_busy", dif.busy, 1'b1);
    chk("b2b_prep_mag", mag_q, 32'd7);
    wait_done("b2b", 1, 6, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    @(negedge clk);

    // Reset in the middle of a 32-iteration divide.
    issue(0, 32'hFFFF_FFFF, 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", dif.busy, 0);
    chk("rst_mid_done", dif.done, 0);
    chk("rst_mid_q", dif.quotient, 0);
    chk("rst_mid_r", dif.remainder, 0);
    chk("rst_mid_mag", mag_q, 0);
    issue(1, 32'd1000, 32'hFFFF_FFFD);
    wait_done("after_rst", 1, 13, 32'hFFFF_FEB3, 32'd1);
    @(negedge clk);

    // Random traffic: starts at any time, occasional resets, all checked by the model.
    for (int c = 0; c < 6000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      dif.start = ($urandom_range(0, 5) == 0);
      dif.is_signed = $urandom_range(0, 1);
      dif.dividend = rand_word();
      dif.divisor = rand_word();
      lz_force = $urandom_range(0, 1);
      @(negedge clk);
    end
    rst = 1'b0; dif.start = 1'b0;
    repeat (40) @(negedge clk);
    chk("random_ops_completed", (m_ndone > 100), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
